// File: rtl/sample_points_ctrl.sv
// Per-ray sample scheduler: derives near/far/step for one ray,
// then issues N_SAMPLES depths t_k over a valid/ready handshake.
module sample_points_ctrl #(
  parameter int NTOTAL_BITS = 16,
  parameter int NFRAC_BITS  = 8,
  parameter int N_SAMPLES   = 16,
  parameter int LOG2_N      = 4,
  parameter logic [NTOTAL_BITS-1:0] NEAR_DELTA = 16'h0100,
  parameter logic [NTOTAL_BITS-1:0] FAR_DELTA  = 16'h0100,
  parameter logic [NTOTAL_BITS-1:0] DEF_NEAR   = 16'h0080,
  parameter logic [NTOTAL_BITS-1:0] DEF_FAR    = 16'h0480
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [NTOTAL_BITS-1:0]     gt_depth,
  input  logic [3*NTOTAL_BITS-1:0]   rays_o,
  input  logic [3*NTOTAL_BITS-1:0]   rays_d,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [NTOTAL_BITS-1:0]     o_t,
  output logic [LOG2_N-1:0]          o_idx,
  output logic                       o_last,
  output logic [3*NTOTAL_BITS-1:0]   o_rays_o,
  output logic [3*NTOTAL_BITS-1:0]   o_rays_d,
  output logic                       o_ray_done,
  output logic                       o_busy
);

  localparam int W = NTOTAL_BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  localparam logic [LOG2_N-1:0] LAST_IDX =
    LOG2_N'(N_SAMPLES - 1);

  localparam logic signed [W:0] MAX_POS =
    {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] NEAR_X =
    {NEAR_DELTA[W-1], NEAR_DELTA};
  localparam logic signed [W:0] FAR_X =
    {FAR_DELTA[W-1], FAR_DELTA};
  localparam logic signed [W:0] DNEAR_X =
    {DEF_NEAR[W-1], DEF_NEAR};
  localparam logic signed [W:0] DFAR_X =
    {DEF_FAR[W-1], DEF_FAR};

  logic [1:0]         state;
  logic [W-1:0]       gt_q;
  logic [3*W-1:0]     ro_q;
  logic [3*W-1:0]     rd_q;
  logic [W-1:0]       t_q;
  logic [W-1:0]       step_q;
  logic [LOG2_N-1:0]  idx_q;
  logic               done_q;

  logic signed [W:0]  gt_x;
  logic signed [W:0]  sub_x;
  logic signed [W:0]  add_x;
  logic signed [W:0]  near_x;
  logic signed [W:0]  far_x;
  logic signed [W:0]  diff_x;
  logic signed [W:0]  step_x;
  logic               gt_pos;
  logic               unused_bits;

  // Bounds are evaluated one bit wider so clamp and saturation
  // decisions see the true sign of each intermediate.
  always_comb begin
    gt_x   = {gt_q[W-1], gt_q};
    gt_pos = !gt_q[W-1] && (|gt_q);
    sub_x  = gt_x - NEAR_X;
    add_x  = gt_x + FAR_X;
    near_x = DNEAR_X;
    far_x  = DFAR_X;
    if (gt_pos) begin
      near_x = (sub_x < 0) ? '0 : sub_x;
      far_x  = (add_x > MAX_POS) ? MAX_POS : add_x;
    end
    diff_x = far_x - near_x;
    step_x = '0;
    if (diff_x > 0)
      step_x = diff_x >>> LOG2_N;
  end

  assign unused_bits = near_x[W] ^ step_x[W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      gt_q   <= '0;
      ro_q   <= '0;
      rd_q   <= '0;
      t_q    <= '0;
      step_q <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (i_valid) begin
            gt_q  <= gt_depth;
            ro_q  <= rays_o;
            rd_q  <= rays_d;
            state <= S_SETUP;
          end
        end
        (state == S_SETUP): begin
          t_q    <= near_x[W-1:0];
          step_q <= step_x[W-1:0];
          idx_q  <= '0;
          state  <= S_ISSUE;
        end
        (state == S_ISSUE): begin
          if (i_ready) begin
            if (idx_q == LAST_IDX) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
              t_q   <= t_q + step_q;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Ready is masked by rst_n so nothing is offered while held in reset.
  assign o_ready    = rst_n && (state == S_IDLE);
  assign o_valid    = (state == S_ISSUE);
  assign o_busy     = (state != S_IDLE);
  assign o_t        = t_q;
  assign o_idx      = idx_q;
  assign o_last     = o_valid && (idx_q == LAST_IDX);
  assign o_rays_o   = ro_q;
  assign o_rays_d   = rd_q;
  assign o_ray_done = done_q;

endmodule
